router_sync: RTL

- Packet-routing synchroniser between the router input FSM and the three output FIFOs.
- Latches the 2-bit destination address from each packet header.
- Steers the FSM's single write strobe to the selected FIFO and returns that FIFO's full flag to the FSM.
- Drives per-port valid flags to the external readers and generates a per-FIFO soft_reset pulse when a reader ignores valid data for TIMEOUT cycles.

---
 rtl/router_sync_if.sv | 47 ++++
 rtl/router_sync.sv | 93 +++++++++
 2 files changed

// File: rtl/router_sync_if.sv
// rtl/router_sync_if.sv - router_sync FSM/FIFO/reader signal bundle; SYNC_TIMEOUT_STATUS_EN adds status signals
interface router_sync_if;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic       full_0, full_1, full_2;
    logic       empty_0, empty_1, empty_2;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
`ifdef SYNC_TIMEOUT_STATUS_EN
    logic       timeout_clr;
    logic [2:0] timeout_flags;

    modport master (
        output detect_add, data_in, write_enb_reg,
        output full_0, full_1, full_2, empty_0, empty_1, empty_2,
        output read_enb_0, read_enb_1, read_enb_2, timeout_clr,
        input  write_enb, fifo_full, vld_out_0, vld_out_1, vld_out_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2, timeout_flags
    );
    modport slave (
        input  detect_add, data_in, write_enb_reg,
        input  full_0, full_1, full_2, empty_0, empty_1, empty_2,
        input  read_enb_0, read_enb_1, read_enb_2, timeout_clr,
        output write_enb, fifo_full, vld_out_0, vld_out_1, vld_out_2,
        output soft_reset_0, soft_reset_1, soft_reset_2, timeout_flags
    );
`else
    modport master (
        output detect_add, data_in, write_enb_reg,
        output full_0, full_1, full_2, empty_0, empty_1, empty_2,
        output read_enb_0, read_enb_1, read_enb_2,
        input  write_enb, fifo_full, vld_out_0, vld_out_1, vld_out_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2
    );
    modport slave (
        input  detect_add, data_in, write_enb_reg,
        input  full_0, full_1, full_2, empty_0, empty_1, empty_2,
        input  read_enb_0, read_enb_1, read_enb_2,
        output write_enb, fifo_full, vld_out_0, vld_out_1, vld_out_2,
        output soft_reset_0, soft_reset_1, soft_reset_2
    );
`endif
endinterface

// File: rtl/router_sync.sv
// rtl/router_sync.sv - router address latch, write steering and per-FIFO read timeout; SYNC_TIMEOUT_STATUS_EN adds sticky timeout flags
module router_sync #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    router_sync_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]            addr_q, addr_d;
    logic [2:0]            empty, rd_en, full, stall;
    logic [2:0]            sr_q, sr_d;
    logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]            we;
    logic                  ff;

    assign empty = {bus.empty_2, bus.empty_1, bus.empty_0};
    assign rd_en = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};
    assign full  = {bus.full_2, bus.full_1, bus.full_0};
    assign stall = ~empty & ~rd_en;

    assign addr_d = bus.detect_add ? bus.data_in : addr_q;

    // Decoding uses the latched address, so a header arriving with a write strobe takes effect next cycle.
    always_comb begin
        we = 3'b000;
        ff = 1'b0;
        case (addr_q)
            2'b00:   begin we = 3'b001; ff = full[0]; end
            2'b01:   begin we = 3'b010; ff = full[1]; end
            2'b10:   begin we = 3'b100; ff = full[2]; end
            default: begin we = 3'b000; ff = 1'b0;    end
        endcase
        if (!bus.write_enb_reg) begin
            we = 3'b000;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        sr_d  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (!stall[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i] = '0;
                sr_d[i]  = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q <= 2'b11;
            cnt_q  <= '0;
            sr_q   <= 3'b000;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            sr_q   <= sr_d;
        end
    end

    assign bus.write_enb    = we;
    assign bus.fifo_full    = ff;
    assign bus.vld_out_0    = ~empty[0];
    assign bus.vld_out_1    = ~empty[1];
    assign bus.vld_out_2    = ~empty[2];
    assign bus.soft_reset_0 = sr_q[0];
    assign bus.soft_reset_1 = sr_q[1];
    assign bus.soft_reset_2 = sr_q[2];

`ifdef SYNC_TIMEOUT_STATUS_EN
    logic [2:0] flags_q, flags_d;

    // A pulse on the same edge as a clear still leaves its flag set.
    assign flags_d = (flags_q & ~{3{bus.timeout_clr}}) | sr_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q <= 3'b000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign bus.timeout_flags = flags_q;
`endif
endmodule
